// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter.
package apb_arb_pkg;

   localparam int APB_ARB_MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_arb_state_e;

   // Width of a requester index; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: the search starts one past ptr and wraps.
module apb_rr_pick
   import apb_arb_pkg::*;
#(
   parameter int NB_REQ = 2,
   localparam int IDX_W = idx_width(NB_REQ)
) (
   input  logic [NB_REQ-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NB_REQ-1:0] gnt,
   output logic [IDX_W-1:0]  idx,
   output logic              valid
);

   // First active requester after ptr, scanning modulo NB_REQ.
   always_comb begin
      int         cand;
      logic [IDX_W-1:0] cand_idx;
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      cand     = 0;
      cand_idx = '0;
      gnt      = '0;
      idx      = '0;
      valid    = 1'b0;
      for (int i = 1; i <= NB_REQ; i++) begin
         cand     = (int'(ptr) + i) % NB_REQ;
         cand_idx = IDX_W'(cand);
         if (!valid && req[cand_idx]) begin
            valid         = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one downstream APB slave port between NB_REQ requesters, one
// complete transfer at a time, with round-robin grant and stall timeout.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NB_REQ         = 2,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NB_REQ-1:0]                  req_psel_i,
   input  logic [NB_REQ-1:0]                  req_penable_i,
   input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_paddr_i,
   input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_pwdata_i,
   input  logic [NB_REQ-1:0]                  req_pwrite_i,
   output logic [APB_DATA_WIDTH-1:0]          req_prdata_o,
   output logic [NB_REQ-1:0]                  req_pready_o,
   output logic [NB_REQ-1:0]                  req_pslverr_o,
   output logic                               m_psel_o,
   output logic                               m_penable_o,
   output logic                               m_pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0]          m_paddr_o,
   output logic [APB_DATA_WIDTH-1:0]          m_pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0]          m_prdata_i,
   input  logic                               m_pready_i,
   input  logic                               m_pslverr_i,
   output logic [NB_REQ-1:0]                  grant_o,
   output logic                               timeout_o
);

   localparam int IDX_W = idx_width(NB_REQ);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   apb_arb_state_e              state_q, state_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [NB_REQ-1:0]           grant_q, grant_d;
   logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic                        pwrite_q, pwrite_d;
   logic                        psel_q, psel_d;
   logic                        penable_q, penable_d;
   logic [NB_REQ-1:0]           pready_q, pready_d;
   logic [NB_REQ-1:0]           pslverr_q, pslverr_d;
   logic [APB_DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;

   logic [NB_REQ-1:0]           pick_gnt;
   logic [IDX_W-1:0]            pick_idx;
   logic                        pick_valid;
   logic [CNT_W:0]              cnt_inc;
   logic                        limit_hit;
   logic                        abort;

   // PENABLE from the requesters carries no arbitration meaning.
   logic unused_penable;
   assign unused_penable = ^req_penable_i;

   apb_rr_pick #(.NB_REQ(NB_REQ)) u_pick (
      .req   (req_psel_i),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // cnt_q counts completed stalled ACCESS cycles; this one would make it cnt_q+1.
   assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign limit_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == (CNT_W+1)'(TIMEOUT_CYCLES));
   assign abort     = (state_q == ACCESS) && !m_pready_i && limit_hit;

   // Next-state and next-output computation; outputs are registered from these.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      cnt_d     = cnt_q;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pready_d  = '0;
      pslverr_d = '0;
      prdata_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d  = SETUP;
               ptr_d    = pick_idx;
               grant_d  = pick_gnt;
               paddr_d  = req_paddr_i[pick_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
               pwdata_d = req_pwdata_i[pick_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
               pwrite_d = req_pwrite_i[pick_idx];
               psel_d   = 1'b1;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            psel_d    = 1'b1;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ACCESS: begin
            if (m_pready_i) begin
               state_d   = RESP;
               pready_d  = grant_q;
               pslverr_d = grant_q & {NB_REQ{m_pslverr_i}};
               prdata_d  = m_prdata_i;
            end else if (limit_hit) begin
               state_d   = RESP;
               pready_d  = grant_q;
               pslverr_d = grant_q;
            end else begin
               psel_d    = 1'b1;
               penable_d = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst_i) begin
         state_q   <= IDLE;
         ptr_q     <= IDX_W'(NB_REQ - 1);
         grant_q   <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pready_q  <= '0;
         pslverr_q <= '0;
         prdata_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         cnt_q     <= cnt_d;
      end
   end

   assign m_psel_o      = psel_q;
   assign m_penable_o   = penable_q;
   assign m_pwrite_o    = pwrite_q;
   assign m_paddr_o     = paddr_q;
   assign m_pwdata_o    = pwdata_q;
   assign req_pready_o  = pready_q;
   assign req_pslverr_o = pslverr_q;
   assign req_prdata_o  = prdata_q;
   assign grant_o       = grant_q;
   assign timeout_o     = abort;

endmodule
